// File: rtl/apb_pad_cfg_regs_if.sv
// APB bus bundle for the pad configuration register file.
// The register block connects to the slave modport.
interface apb_pad_cfg_regs_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pad_cfg_regs.sv
// APB register file holding 64 six-bit pad configuration fields, a sticky lock
// and synchronized pad input read-back. Every transfer takes one wait state.
module apb_pad_cfg_regs #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_PADS         = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    apb_pad_cfg_regs_if.slave      apb,
    input  logic [N_PADS-1:0]      pad_in_i,
    output logic [N_PADS-1:0][5:0] pad_cfg_o,
    output logic                   cfg_locked_o,
    output logic                   cfg_update_o
);

    if (N_PADS != 64) begin : g_bad_n_pads
        $error("apb_pad_cfg_regs: N_PADS must be 64");
    end
    if ($bits(apb.PADDR) != APB_ADDR_WIDTH) begin : g_bad_addr_w
        $error("apb_pad_cfg_regs: interface address width mismatch");
    end

    typedef enum logic {IDLE, RESP} state_t;

    state_t                 state;
    logic [N_PADS-1:0][5:0] cfg_q;
    logic                   lock_q;
    logic [N_PADS-1:0]      pad_sync_p0;
    logic [N_PADS-1:0]      pad_sync_p1;

    logic [5:0]  off;
    logic        is_cfg;
    logic        is_padin;
    logic        is_lock;
    logic        acc_err;
    logic        wr_cfg;
    logic        wr_lock;
    logic [31:0] rd_mux;

    // Only the word offset matters; byte lanes and upper address bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[1:0], apb.PADDR[APB_ADDR_WIDTH-1:8],
                           apb.PWDATA[31:30], apb.PWDATA[23:22],
                           apb.PWDATA[15:14], apb.PWDATA[7:6]};

    assign off      = apb.PADDR[7:2];
    assign is_cfg   = (off[5:4] == 2'b00);
    assign is_padin = (off == 6'h10) || (off == 6'h11);
    assign is_lock  = (off == 6'h12);
    assign acc_err  = !(is_cfg || is_padin || is_lock)
                    || (apb.PWRITE && is_padin)
                    || (apb.PWRITE && is_cfg && lock_q);
    assign wr_cfg   = apb.PWRITE && is_cfg && !lock_q;
    assign wr_lock  = apb.PWRITE && is_lock && apb.PWDATA[0];

    always_comb begin
        rd_mux = '0;
        if (is_cfg) begin
            for (int k = 0; k < 4; k++) begin
                rd_mux[8*k +: 6] = cfg_q[{off[3:0], 2'(k)}];
            end
        end else if (off == 6'h10) begin
            rd_mux = pad_sync_p1[31:0];
        end else if (off == 6'h11) begin
            rd_mux = pad_sync_p1[63:32];
        end else if (is_lock) begin
            rd_mux = {31'b0, lock_q};
        end
    end

    // Register writes commit on the edge that leaves IDLE, ahead of PREADY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            apb.PREADY   <= 1'b0;
            apb.PSLVERR  <= 1'b0;
            apb.PRDATA   <= '0;
            cfg_update_o <= 1'b0;
            lock_q       <= 1'b0;
            cfg_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    apb.PREADY   <= 1'b0;
                    apb.PSLVERR  <= 1'b0;
                    cfg_update_o <= 1'b0;
                    if (apb.PSEL && apb.PENABLE) begin
                        state       <= RESP;
                        apb.PREADY  <= 1'b1;
                        apb.PSLVERR <= acc_err;
                        if (apb.PWRITE) begin
                            if (wr_cfg) begin
                                for (int k = 0; k < 4; k++) begin
                                    cfg_q[{off[3:0], 2'(k)}] <= apb.PWDATA[8*k +: 6];
                                end
                                cfg_update_o <= 1'b1;
                            end
                            if (wr_lock) begin
                                lock_q <= 1'b1;
                            end
                        end else begin
                            apb.PRDATA <= rd_mux;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    apb.PREADY   <= 1'b0;
                    apb.PSLVERR  <= 1'b0;
                    cfg_update_o <= 1'b0;
                end
            endcase
        end
    end

    // Output copy of the configuration and the two-flop pad synchronizer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_cfg_o   <= '0;
            pad_sync_p0 <= '0;
            pad_sync_p1 <= '0;
        end else begin
            pad_cfg_o   <= cfg_q;
            pad_sync_p0 <= pad_in_i;
            pad_sync_p1 <= pad_sync_p0;
        end
    end

    assign cfg_locked_o = lock_q;

endmodule

// File: tb/tb_apb_pad_cfg_regs.sv
// Self-checking bench for apb_pad_cfg_regs: directed register-map scenarios plus
// randomized APB traffic compared against a register-map level reference model.
module tb_apb_pad_cfg_regs;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [63:0]     pad_in = '0;
    logic [63:0][5:0] pad_cfg;
    logic            locked;
    logic            update;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the register map as software sees it.
    logic [5:0]  cfg_m [64];
    logic        locked_m;
    logic [63:0] pad_m;
    logic [31:0] last_rd_m;

    apb_pad_cfg_regs_if #(.APB_ADDR_WIDTH(12)) apb ();

    apb_pad_cfg_regs #(.APB_ADDR_WIDTH(12), .N_PADS(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .apb          (apb),
        .pad_in_i     (pad_in),
        .pad_cfg_o    (pad_cfg),
        .cfg_locked_o (locked),
        .cfg_update_o (update)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] model_vec();
        logic [383:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[6*i +: 6] = cfg_m[i];
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input logic [5:0] off);
        logic [31:0] v;
        v = '0;
        if (off < 16) begin
            for (int k = 0; k < 4; k++) v[8*k +: 8] = {2'b00, cfg_m[off*4 + k]};
        end else if (off == 16) v = pad_m[31:0];
        else if (off == 17) v = pad_m[63:32];
        else if (off == 18) v = {31'b0, locked_m};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) cfg_m[i] = '0;
        locked_m  = 1'b0;
        last_rd_m = '0;
    endtask

    task automatic idle_bus();
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pad_cfg", pad_cfg, '0);
        chk("rst_pready", apb.PREADY, 1'b0);
        chk("rst_pslverr", apb.PSLVERR, 1'b0);
        chk("rst_prdata", apb.PRDATA, 32'h0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_update", update, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_pads(input logic [63:0] v);
        @(posedge clk); #1;
        pad_in = v;
        repeat (3) @(posedge clk);
        pad_m = v;
    endtask

    // One APB transfer; all outcomes are compared against the model.
    task automatic xfer(input bit wr, input logic [5:0] off, input logic [31:0] wd,
                        input bit drop_psel, output logic [31:0] rd);
        int          r;
        int          cyc;
        bit          got;
        logic        err;
        logic        upd;
        logic        exp_err;
        logic        exp_upd;
        logic [31:0] exp_rd;
        r = $urandom;
        exp_err = (off > 18) || (wr && (off == 16 || off == 17)) || (wr && off < 16 && locked_m);
        exp_upd = wr && (off < 16) && !exp_err;
        exp_rd  = model_rd(off);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = {r[3:0], off, r[5:4]}; apb.PWDATA = wd;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        cyc = 0; got = 0; err = 0; upd = 0; rd = '0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (apb.PREADY) begin
                got = 1; rd = apb.PRDATA; err = apb.PSLVERR; upd = update;
            end else if (drop_psel && cyc == 1) begin
                @(posedge clk); #1;
                apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
            end
        end
        chk("ready_cycle", cyc, 2);
        chk("pslverr", err, exp_err);
        chk("update_pulse", upd, exp_upd);
        if (!wr) chk("prdata", rd, exp_rd);
        if (wr && !exp_err) begin
            if (off < 16) for (int k = 0; k < 4; k++) cfg_m[off*4 + k] = wd[8*k +: 6];
            if (off == 18 && wd[0]) locked_m = 1'b1;
        end
        if (!wr) last_rd_m = exp_rd;
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        chk("pready_low_after", apb.PREADY, 1'b0);
        chk("update_low_after", update, 1'b0);
        chk("prdata_hold", apb.PRDATA, last_rd_m);
        chk("pad_cfg", pad_cfg, model_vec());
        chk("locked", locked, locked_m);
    endtask

    initial begin
        logic [31:0] rd;
        int          r;
        logic [5:0]  off;
        idle_bus();
        pad_m = '0;
        model_reset();

        // Reset state and first read
        do_reset();
        xfer(0, 6'd5, '0, 0, rd);

        // PADCFG3 full write, unused bits dropped
        xfer(1, 6'd3, 32'hFFFF_FFFF, 0, rd);
        for (int i = 12; i < 16; i++) chk("pad12_15", pad_cfg[i], 6'h3F);
        xfer(0, 6'd3, '0, 0, rd);
        chk("padcfg3_readback", rd, 32'h3F3F_3F3F);

        // Pad input synchronizer and PADIN write error
        set_pads(64'hA5A5_0000_0000_1234);
        xfer(0, 6'h10, '0, 0, rd);
        chk("padin_lo", rd, 32'h0000_1234);
        xfer(0, 6'h11, '0, 0, rd);
        chk("padin_hi", rd, 32'hA5A5_0000);
        xfer(1, 6'h10, 32'hFFFF_FFFF, 0, rd);

        // Lock behaviour
        xfer(1, 6'h12, 32'h1, 0, rd);
        xfer(1, 6'd0, 32'h0101_0101, 0, rd);
        for (int i = 0; i < 4; i++) chk("pad0_3_locked", pad_cfg[i], 6'h00);
        xfer(1, 6'h12, 32'h0, 0, rd);
        xfer(1, 6'h12, 32'h1, 0, rd);
        xfer(0, 6'h12, '0, 0, rd);
        do_reset();
        chk("unlocked_after_reset", locked, 1'b0);

        // Unmapped read followed by a mapped read
        xfer(0, 6'h20, '0, 0, rd);
        xfer(0, 6'd3, '0, 0, rd);

        // PSEL dropped during the response still commits
        xfer(1, 6'd9, 32'h2A15_3F01, 1, rd);
        xfer(0, 6'd9, '0, 0, rd);

        // Randomized traffic
        for (int n = 0; n < 160; n++) begin
            r = $urandom;
            if (n % 60 == 59) do_reset();
            if (n % 20 == 10) set_pads({$urandom, $urandom});
            if (r[1:0] == 2'b00) off = 6'($urandom_range(0, 63));
            else if (r[4:2] == 3'b000) off = 6'd18;
            else off = 6'($urandom_range(0, 17));
            xfer(r[8], off, $urandom, 0, rd);
        end

        // Reset during the access cycle of a PADCFG write
        do_reset();
        xfer(1, 6'd7, 32'h1515_1515, 0, rd);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = {4'h0, 6'd7, 2'b00};
        apb.PWDATA = 32'h2A2A_2A2A;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_pad_cfg", pad_cfg, '0);
        chk("midrst_pready", apb.PREADY, 1'b0);
        idle_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_idle_pready", apb.PREADY, 1'b0);
        end
        xfer(0, 6'd7, '0, 0, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
